// File: rtl/gcd_controller.sv
// gcd_controller: sequencing FSM for a 16-bit subtractive GCD datapath.
// Loads A then B from data_in, then subtracts the smaller from the larger until A==B.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, abort      begin a run (when idle) / cancel a run (when busy)
//   gt, lt, eq        comparator flags for aout vs bout
//   lda, ldb          load enables for datapath registers A and B
//   sel1, sel2        subtractor minuend / subtrahend select (0 = aout, 1 = bout)
//   sel_in            bus select (0 = subtractor, 1 = data_in)
//   busy, done, err   run in progress / last run converged / last run hit the limit
//   iter              subtractions performed in the current or last run
module gcd_controller #(
    parameter int unsigned MAX_ITER = 65535,
    parameter int unsigned ITER_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              gt,
    input  logic              lt,
    input  logic              eq,
    output logic              lda,
    output logic              ldb,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_B,
        RUN
    } state_t;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_t state;

    logic same;
    logic go_a;
    logic limit;

    // Contradictory or missing ordering flags are treated as equality,
    // so the run always terminates instead of subtracting blindly.
    assign same  = eq | (gt == lt);
    assign go_a  = ~same & gt;
    assign limit = (iter == MAX_CNT);

    // Mealy datapath controls; forced to defaults while reset is held.
    always_comb begin
        lda    = 1'b0;
        ldb    = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b1;
        sel_in = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    sel_in = 1'b1;
                    lda    = start;
                end
                LOAD_B: begin
                    sel_in = 1'b1;
                    ldb    = ~abort;
                end
                RUN: begin
                    if (!abort && !same && !limit) begin
                        if (go_a) begin
                            lda = 1'b1;
                        end else begin
                            sel1 = 1'b1;
                            sel2 = 1'b0;
                            ldb  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            iter  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_B;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                        iter  <= '0;
                    end
                end
                LOAD_B: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end else if (same) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (limit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench for gcd_controller with a behavioural
// A/B datapath; one instance at default MAX_ITER, one at MAX_ITER=8.
module tb_gcd_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start8;
    logic        abort;
    logic [15:0] data_in;

    logic        lda, ldb, sel1, sel2, sel_in, busy, done, err;
    logic [15:0] iter;
    logic        gt, lt, eq;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] bus;

    logic        lda8, ldb8, sel1_8, sel2_8, sel_in8, busy8, done8, err8;
    logic [15:0] iter8;
    logic        gt8, lt8, eq8;
    logic [15:0] a8 = '0;
    logic [15:0] b8 = '0;
    logic [15:0] bus8;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    gcd_controller u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .lda    (lda),
        .ldb    (ldb),
        .sel1   (sel1),
        .sel2   (sel2),
        .sel_in (sel_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .iter   (iter)
    );

    gcd_controller #(.MAX_ITER(8), .ITER_W(16)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .abort  (abort),
        .gt     (gt8),
        .lt     (lt8),
        .eq     (eq8),
        .lda    (lda8),
        .ldb    (ldb8),
        .sel1   (sel1_8),
        .sel2   (sel2_8),
        .sel_in (sel_in8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .iter   (iter8)
    );

    // Behavioural datapaths
    always_comb begin
        bus  = sel_in ? data_in : ((sel1 ? b : a) - (sel2 ? b : a));
        gt   = a > b;
        lt   = a < b;
        eq   = a == b;
        bus8 = sel_in8 ? data_in : ((sel1_8 ? b8 : a8) - (sel2_8 ? b8 : a8));
        gt8  = a8 > b8;
        lt8  = a8 < b8;
        eq8  = a8 == b8;
    end

    always @(posedge clk) begin
        if (lda)  a  <= bus;
        if (ldb)  b  <= bus;
        if (lda8) a8 <= bus8;
        if (ldb8) b8 <= bus8;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start8  = 1'b0;
        abort   = 1'b0;
        data_in = '0;

        // Reset: outputs at defaults even with start asserted
        tick;
        start = 1'b1;
        #1;
        chk("rst_lda", lda, 0);
        chk("rst_sel_in", sel_in, 0);
        chk("rst_sel2", sel2, 1);
        chk("rst_sel1", sel1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_iter", iter, 0);
        tick;
        rst   = 1'b0;
        start = 1'b0;

        // 48/18 -> 6 in 4 subtractions
        tick;
        start   = 1'b1;
        data_in = 16'd48;
        #1;
        chk("t1_lda", lda, 1);
        chk("t1_sel_in", sel_in, 1);
        tick;
        start   = 1'b0;
        data_in = 16'd18;
        #1;
        chk("t1_busy_T1", busy, 1);
        chk("t1_ldb", ldb, 1);
        chk("t1_a_load", a, 48);
        tick;
        chk("t1_b_load", b, 18);
        repeat (4) tick;
        chk("t1_busy_T6", busy, 1);
        chk("t1_done_T6", done, 0);
        tick;
        chk("t1_done_T7", done, 1);
        chk("t1_busy_T7", busy, 0);
        chk("t1_iter", iter, 4);
        chk("t1_aout", a, 6);
        chk("t1_err", err, 0);

        // 35/35: done with zero iterations, no loads in RUN
        start   = 1'b1;
        data_in = 16'd35;
        tick;
        start = 1'b0;
        tick;
        chk("t2_lda_run", lda, 0);
        chk("t2_ldb_run", ldb, 0);
        tick;
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_iter", iter, 0);
        chk("t2_aout", a, 35);

        // MAX_ITER=8, A=0 B=5: err at T0+11
        start8  = 1'b1;
        data_in = 16'd0;
        tick;
        start8  = 1'b0;
        data_in = 16'd5;
        tick;
        repeat (8) tick;
        chk("t3_err_T10", err8, 0);
        chk("t3_busy_T10", busy8, 1);
        tick;
        chk("t3_err_T11", err8, 1);
        chk("t3_busy_T11", busy8, 0);
        chk("t3_done", done8, 0);
        chk("t3_iter", iter8, 8);

        // 65535/1: 65534 subtractions
        start   = 1'b1;
        data_in = 16'd65535;
        tick;
        start   = 1'b0;
        data_in = 16'd1;
        n = 1;
        while (!done && n < 70000) begin
            tick;
            n++;
        end
        chk("t4_done", done, 1);
        chk("t4_cycles", n, 65537);
        chk("t4_iter", iter, 65534);
        chk("t4_aout", a, 1);
        chk("t4_err", err, 0);

        // Abort in 3rd RUN cycle of 48/18
        start   = 1'b1;
        data_in = 16'd48;
        tick;
        start   = 1'b0;
        data_in = 16'd18;
        tick;
        tick;
        tick;
        abort = 1'b1;
        #1;
        chk("t5_abort_lda", lda, 0);
        chk("t5_abort_ldb", ldb, 0);
        tick;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        chk("t5_iter", iter, 2);
        chk("t5_a", a, 12);

        // Restart 21/14 with abort still high: start wins
        start   = 1'b1;
        data_in = 16'd21;
        #1;
        chk("t5r_lda", lda, 1);
        tick;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = 16'd14;
        chk("t5r_busy", busy, 1);
        tick;
        tick;
        tick;
        chk("t5r_done_T4", done, 0);
        tick;
        chk("t5r_done", done, 1);
        chk("t5r_iter", iter, 2);
        chk("t5r_aout", a, 7);

        // Start while busy ignored; reset mid-run
        start   = 1'b1;
        data_in = 16'd48;
        tick;
        start   = 1'b0;
        data_in = 16'd18;
        tick;
        tick;
        start   = 1'b1;
        data_in = 16'd99;
        #1;
        chk("t6_sel_in", sel_in, 0);
        chk("t6_lda", lda, 1);
        tick;
        start = 1'b0;
        chk("t6_iter", iter, 2);
        chk("t6_a", a, 12);
        chk("t6_b", b, 18);
        chk("t6_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ldb", ldb, 0);
        chk("t6_rst_sel1", sel1, 0);
        tick;
        rst = 1'b0;
        chk("t6_busy_rst", busy, 0);
        chk("t6_done_rst", done, 0);
        chk("t6_err_rst", err, 0);
        chk("t6_iter_rst", iter, 0);
        chk("t6_a_kept", a, 12);
        chk("t6_b_kept", b, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Sequencing FSM for the 16-bit subtractive GCD datapath (registers A/B, operand muxes, subtractor, comparator). It loads two operands from `data_in` into A and B over consecutive cycles. It then iterates A←A−B or B←B−A under control of the comparator flags until A==B, and reports completion, iteration count, or a runaway error. The GCD result is left in register A (datapath `aout`) when `done` rises.

## Interface
- `MAX_ITER`, default 65535: maximum subtractions per run before abort with error; legal range 1..2^ITER_W−1.
- `ITER_W`, default 16: width of the iteration counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin operation; sampled only when not busy; operand A must be on `data_in` in this cycle.
- `abort`  in  1  cancel a run in progress; ignored when not busy.
- `gt`, `lt`, `eq`  in  1 each  comparator flags for aout vs bout (gt: A>B).
- `lda`, `ldb`  out  1 each  load enables for datapath registers A and B.
- `sel1`  out  1  subtractor minuend select: 0 = aout, 1 = bout.
- `sel2`  out  1  subtractor subtrahend select: 0 = aout, 1 = bout.
- `sel_in`  out  1  bus select: 0 = subtractor output, 1 = `data_in`.
- `busy`  out  1  run in progress (LOAD_B or RUN).
- `done`  out  1  sticky: last run ended with A==B.
- `err`  out  1  sticky: last run hit MAX_ITER without A==B.
- `iter`  out  ITER_W  number of subtractions performed in the current or last run.

## Operation
- States: IDLE, LOAD_B, RUN. `lda`/`ldb`/`sel*` are Mealy (state + inputs); `busy`/`done`/`err`/`iter` are registered.
- Default drive in every state: lda=ldb=0, sel1=0, sel2=1, sel_in=0.
- IDLE:
  - sel_in=1, lda=start.
  - On start: → LOAD_B; clear done, err, iter.
- LOAD_B:
  - sel_in=1, ldb=1 (operand B must be on `data_in` this cycle).
  - → RUN.
  - abort: ldb=0, → IDLE.
- RUN (each cycle):
  - abort: no load, → IDLE; done=err=0; iter holds.
  - else eq: no load, → IDLE, done←1.
  - else iter==MAX_ITER: no load, → IDLE, err←1.
  - else gt: sel1=0, sel2=1, lda=1 (A←A−B); iter←iter+1.
  - else lt: sel1=1, sel2=0, ldb=1 (B←B−A); iter←iter+1.
- Flag priority in RUN: abort > eq > iteration limit > gt > lt.
- If gt and lt are both low, or more than one flag is high, treat the cycle as eq.
- Subtraction is 16-bit unsigned; the controller selects operands so the result never wraps.
- Zero operands:
  - A=B=0: done after zero iterations, result 0.
  - Exactly one operand zero: never converges; terminates via err.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: start wins.

## Timing
- Reset: state IDLE; busy=done=err=0; iter=0.
  - While rst=1, lda=ldb=0, sel1=0, sel2=1, sel_in=0 regardless of inputs.
  - Reset mid-run returns to IDLE; A/B register contents are untouched.
- Start cycle T0: A loads at the end of T0.
- T1: B loads.
- T2 onward: one compare/subtract per cycle, using flags from the registered A/B.
- With N subtractions:
  - `done` is high from cycle T0+3+N; `busy` is low from the same cycle.
  - `busy` is high from T1 through T0+2+N.
- Error case: `err` is high from T0+3+MAX_ITER; iter=MAX_ITER.
- done/err stay high until the next accepted start or reset.
- A new start may be issued in the first cycle `busy` is low.

## Test plan
- Load A=48, B=18, start at T0 -> 4 subtractions (48,18→30,18→12,18→12,6→6,6); done=1 at T0+7; iter=4; aout=6.
- A=B=35 -> done at T0+3; iter=0; aout=35; no lda/ldb asserted in RUN.
- MAX_ITER=8, A=0, B=5 -> err=1 at T0+11; done=0; iter=8; busy low the same cycle.
- A=65535, B=1 with default MAX_ITER -> 65534 subtractions, done=1, aout=1, err=0.
- Abort asserted in the 3rd RUN cycle of 48/18 -> IDLE next cycle; done=err=0; iter=2; then restart with 21/14 -> done; aout=7; iter=2.
- rst pulsed mid-run; start pulsed while busy -> immediate IDLE, all flags 0 after rst; mid-run start has no effect on iter or the sequence.
